// File: rtl/fft_2.sv
// fft_2: 4-point radix-2 DIT FFT over 1-bit real samples.
// Capture register, butterfly stage 1, butterfly stage 2 (twiddle -j).
module fft_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] inp,
   output logic       out_valid,
   output logic [2:0] rout_0,
   output logic [2:0] rout_1,
   output logic [2:0] rout_2,
   output logic [2:0] rout_3,
   output logic [2:0] iout_0,
   output logic [2:0] iout_1,
   output logic [2:0] iout_2,
   output logic [2:0] iout_3
);

   logic [3:0]        r_x;
   logic              r_v0;
   logic signed [2:0] r_a0, r_a1, r_b0, r_b1;
   logic              r_v1;
   logic [2:0]        r_re0, r_re1, r_re2, r_re3;
   logic [2:0]        r_im1, r_im3;
   logic              r_v2;

   logic signed [2:0] w_x0, w_x1, w_x2, w_x3;
   logic signed [2:0] w_sum, w_dif, w_neg;

   // zero-extend each 1-bit sample so the butterflies work in signed 3-bit
   assign w_x0 = {2'b00, r_x[0]};
   assign w_x1 = {2'b00, r_x[1]};
   assign w_x2 = {2'b00, r_x[2]};
   assign w_x3 = {2'b00, r_x[3]};

   assign w_sum = r_a0 + r_b0;
   assign w_dif = r_a0 - r_b0;
   assign w_neg = 3'sd0 - r_b1;

   // input capture: samples only move when qualified, valid always shifts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x  <= 4'd0;
         r_v0 <= 1'b0;
      end else begin
         r_v0 <= in_valid;
         if (in_valid) r_x <= inp;
      end
   end

   // stage 1: even/odd pair sums and differences
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a0 <= 3'sd0;
         r_a1 <= 3'sd0;
         r_b0 <= 3'sd0;
         r_b1 <= 3'sd0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= r_v0;
         if (r_v0) begin
            r_a0 <= w_x0 + w_x2;
            r_a1 <= w_x0 - w_x2;
            r_b0 <= w_x1 + w_x3;
            r_b1 <= w_x1 - w_x3;
         end
      end
   end

   // stage 2: combine halves, odd bins rotate b1 by -j
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_re0 <= 3'd0;
         r_re1 <= 3'd0;
         r_re2 <= 3'd0;
         r_re3 <= 3'd0;
         r_im1 <= 3'd0;
         r_im3 <= 3'd0;
         r_v2  <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_re0 <= w_sum;
            r_re2 <= w_dif;
            r_re1 <= r_a1;
            r_re3 <= r_a1;
            r_im1 <= w_neg;
            r_im3 <= r_b1;
         end
      end
   end

   assign out_valid = r_v2;
   assign rout_0    = r_re0;
   assign rout_1    = r_re1;
   assign rout_2    = r_re2;
   assign rout_3    = r_re3;
   assign iout_0    = 3'd0;
   assign iout_1    = r_im1;
   assign iout_2    = 3'd0;
   assign iout_3    = r_im3;

endmodule

// File: tb/tb_fft_2.sv
// tb_fft_2: directed checks of the 4-point FFT pipeline.
// Expected bins are hand constants or the closed-form DFT.
module tb_fft_2;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] inp;
   logic       out_valid;
   logic [2:0] rout_0, rout_1, rout_2, rout_3;
   logic [2:0] iout_0, iout_1, iout_2, iout_3;

   int errs;
   int checks;

   fft_2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .inp       (inp),
      .out_valid (out_valid),
      .rout_0    (rout_0),
      .rout_1    (rout_1),
      .rout_2    (rout_2),
      .rout_3    (rout_3),
      .iout_0    (iout_0),
      .iout_1    (iout_1),
      .iout_2    (iout_2),
      .iout_3    (iout_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // packed {re0,re1,re2,re3,im0,im1,im2,im3}
   localparam logic [23:0] E0001 = {3'd1, 3'd1, 3'd1, 3'd1, 12'd0};
   localparam logic [23:0] E1111 = {3'b100, 3'd0, 3'd0, 3'd0, 12'd0};
   localparam logic [23:0] E0010 = {3'd1, 3'd0, 3'b111, 3'd0,
                                    3'd0, 3'b111, 3'd0, 3'd1};
   localparam logic [23:0] E0101 = {3'd2, 3'd0, 3'd2, 3'd0, 12'd0};
   localparam logic [23:0] E1010 = {3'd2, 3'd0, 3'b110, 3'd0, 12'd0};

   function automatic logic [23:0] dft(input logic [3:0] x);
      int x0, x1, x2, x3;
      logic [2:0] r0, r1, r2, r3, i1, i3;
      x0 = int'(x[0]);
      x1 = int'(x[1]);
      x2 = int'(x[2]);
      x3 = int'(x[3]);
      r0 = 3'(x0 + x1 + x2 + x3);
      r1 = 3'(x0 - x2);
      i1 = 3'(x3 - x1);
      r2 = 3'((x0 + x2) - (x1 + x3));
      r3 = 3'(x0 - x2);
      i3 = 3'(x1 - x3);
      return {r0, r1, r2, r3, 3'd0, i1, 3'd0, i3};
   endfunction

   // apply inputs, clock once, then compare outputs just after the edge
   task automatic step(input logic v, input logic [3:0] x,
                       input logic ev, input logic [23:0] ed,
                       input string tag);
      logic [24:0] obs;
      in_valid = v;
      inp      = x;
      @(posedge clk);
      #1;
      obs = {out_valid, rout_0, rout_1, rout_2, rout_3,
             iout_0, iout_1, iout_2, iout_3};
      checks++;
      assert (obs === {ev, ed}) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, {ev, ed});
      end
   endtask

   initial begin
      errs     = 0;
      checks   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      inp      = 4'd0;

      step(1'b1, 4'b1010, 1'b0, 24'd0, "rst0");
      step(1'b1, 4'b0101, 1'b0, 24'd0, "rst1");
      rst_n = 1'b1;

      step(1'b1, 4'b0001, 1'b0, 24'd0, "lat0");
      step(1'b1, 4'b1111, 1'b0, 24'd0, "lat1");
      step(1'b1, 4'b0010, 1'b1, E0001, "x0001");
      step(1'b1, 4'b0101, 1'b1, E1111, "x1111");
      step(1'b1, 4'b1010, 1'b1, E0010, "x0010");
      step(1'b0, 4'b0000, 1'b1, E0101, "x0101");
      step(1'b0, 4'b0110, 1'b1, E1010, "x1010");
      step(1'b0, 4'b0000, 1'b0, E1010, "hold0");
      step(1'b0, 4'b1001, 1'b0, E1010, "hold1");

      for (int i = 0; i < 18; i++) begin
         step(i < 16, 4'(i), i >= 2,
              (i >= 2) ? dft(4'(i - 2)) : E1010, "sweep");
      end

      step(1'b1, 4'd3, 1'b0, dft(4'd15), "gap0");
      step(1'b1, 4'd5, 1'b0, dft(4'd15), "gap1");
      step(1'b1, 4'd9, 1'b1, dft(4'd3), "pre_rst");
      rst_n = 1'b0;
      step(1'b1, 4'd12, 1'b0, 24'd0, "rst_mid");
      rst_n = 1'b1;
      step(1'b1, 4'd6, 1'b0, 24'd0, "resume0");
      step(1'b1, 4'd10, 1'b0, 24'd0, "resume1");
      step(1'b0, 4'd0, 1'b1, dft(4'd6), "resume2");
      step(1'b0, 4'd0, 1'b1, dft(4'd10), "resume3");
      step(1'b0, 4'd0, 1'b0, dft(4'd10), "drain");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fft_2.md
Name: fft_2

Overview:
- 4-point radix-2 decimation-in-time FFT.
- Input is 4 one-bit real samples; output is 4 complex bins, 3 bits per component.
- Two-stage registered pipeline (butterfly stage 1, butterfly stage 2 with twiddle -j), one new input vector per clock.
- Used as a small transform leaf on a bit-stream front end.

Parameters:
- None. Widths are fixed: 4-bit input vector, 3-bit output components.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  input  1  qualifies inp for this cycle
- inp  input  4  samples x[n] = inp[n], n=0..3, each 0 or 1
- out_valid  output  1  high when rout_*/iout_* hold a valid result
- rout_0  output  3  Re X[0], unsigned 0..4
- rout_1  output  3  Re X[1], two's complement
- rout_2  output  3  Re X[2], two's complement
- rout_3  output  3  Re X[3], two's complement
- iout_0  output  3  Im X[0], always 0
- iout_1  output  3  Im X[1], two's complement
- iout_2  output  3  Im X[2], always 0
- iout_3  output  3  Im X[3], two's complement

Behaviour:
- Transform: X[k] = sum over n of x[n]·e^(-j2πkn/4).
- Closed form:
  - X0 = x0+x1+x2+x3
  - X1 = (x0-x2) + j(x3-x1)
  - X2 = (x0+x2)-(x1+x3)
  - X3 = (x0-x2) + j(x1-x3)
- Stage 1, registered on the first edge after input capture:
  - a0 = x0+x2 (0..2)
  - a1 = x0-x2 (-1..1)
  - b0 = x1+x3 (0..2)
  - b1 = x1-x3 (-1..1)
  - Hold each in 3-bit signed registers, plus a valid bit.
- Stage 2, registered into the output registers:
  - rout_0 = a0+b0; rout_2 = a0-b0
  - rout_1 = a1; iout_1 = -b1
  - rout_3 = a1; iout_3 = b1
  - iout_0 = iout_2 = 0
- Arithmetic: all intermediate math is sign-extended to at least 3 bits; no saturation or overflow is possible.
- rout_0 is the only unsigned output; value 4 is encoded as 3'b100.
- Latency: inp sampled at rising edge N with in_valid=1 appears on the outputs, with out_valid=1, after rising edge N+2.
- Throughput: fully pipelined; back-to-back valid inputs give back-to-back valid outputs.
- in_valid=0 handling:
  - The pipeline valid bit shifts a 0.
  - Data registers hold their previous contents; outputs hold the last result and out_valid drops 2 cycles later.
- Reset: when rst_n=0 at a rising edge, every output register, stage-1 register and valid bit clears to 0 on that edge. Outputs read all-zero with out_valid=0.
- Reset mid-stream: results in flight are discarded. The first out_valid after release comes 2 edges after the first valid input sampled with rst_n=1.
- No combinational path from inp to any output.

Test Plan:
- Reset held 2 cycles while inp toggles → all outputs 0, out_valid 0; after release, inp=4'b0001 with in_valid → 2 cycles later rout_0..3=1, all iout=0, out_valid=1.
- inp=4'b1111 → rout_0=3'b100 (4); rout_1=rout_2=rout_3=0; all iout=0.
- inp=4'b0010 (x1=1) → rout_0=1, rout_1=0, iout_1=3'b111 (-1), rout_2=3'b111 (-1), rout_3=0, iout_3=1.
- inp=4'b0101 → rout_0=2, rout_2=2, others 0. inp=4'b1010 → rout_0=2, rout_2=3'b110 (-2), others 0.
- Sweep all 16 inp values back-to-back, one per cycle, with in_valid=1 → each output equals the closed-form DFT, 2-cycle latency, out_valid continuously 1.
- Deassert rst_n for one cycle mid-sweep → outputs and out_valid go 0 on that edge; valid results resume exactly 2 cycles after the next valid input.
